// File: rtl/rpn_if.sv
// rpn_if: token and result handshake bundle for rpn_evaluator.
//   number_in / number_in_stb / number_in_ack : operand token stream (STB/ACK)
//   sign_in   / sign_in_stb   / sign_in_ack   : operator token stream (STB/ACK)
//   result / error / result_stb / result_ack  : one result per expression (STB/ACK)
//   busy                                      : evaluator is not accepting tokens
// master = token producer / result consumer, slave = evaluator.
interface rpn_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
);
    logic [DATA_W-1:0] number_in;
    logic              number_in_stb;
    logic              number_in_ack;
    logic [DATA_W-1:0] sign_in;
    logic              sign_in_stb;
    logic              sign_in_ack;
    logic [ACC_W-1:0]  result;
    logic [2:0]        error;
    logic              result_stb;
    logic              result_ack;
    logic              busy;

    modport master (
        output number_in, number_in_stb, sign_in, sign_in_stb, result_ack,
        input  number_in_ack, sign_in_ack, result, error, result_stb, busy
    );

    modport slave (
        input  number_in, number_in_stb, sign_in, sign_in_stb, result_ack,
        output number_in_ack, sign_in_ack, result, error, result_stb, busy
    );
endinterface

// File: rtl/rpn_evaluator.sv
// rpn_evaluator: evaluates postfix token streams on an operand stack and returns
// one signed result plus error code per expression.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : rpn_if.slave (number/sign token inputs with ACKs, result STB/ACK, busy)
// Both token STBs high together form the end marker. Errors are sticky until the
// result is taken; tokens arriving while an error is pending are ACKed and dropped.
module rpn_evaluator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int DEPTH  = 16
) (
    input  logic  clk_i,
    input  logic  rst_i,
    rpn_if.slave  bus
);
    localparam int SP_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;
    localparam int CNT_W = $clog2(ACC_W);

    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(DEPTH);
    localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
    localparam logic [SP_W-1:0]   SP_TWO   = SP_W'(2);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACC_W - 1);

    localparam logic [DATA_W-1:0] OP_ADD = DATA_W'(8'h2B);
    localparam logic [DATA_W-1:0] OP_SUB = DATA_W'(8'h2D);
    localparam logic [DATA_W-1:0] OP_MUL = DATA_W'(8'h2A);
    localparam logic [DATA_W-1:0] OP_DIV = DATA_W'(8'h2F);

    localparam logic [2:0] E_OK    = 3'd0;
    localparam logic [2:0] E_UNDER = 3'd1;
    localparam logic [2:0] E_OVER  = 3'd2;
    localparam logic [2:0] E_DIV0  = 3'd3;
    localparam logic [2:0] E_SIGN  = 3'd4;
    localparam logic [2:0] E_END   = 3'd5;

    typedef enum logic [1:0] {S_ACCEPT, S_EXEC, S_DIV, S_DONE} state_t;

    // + - * wrap silently to ACC_W bits.
    function automatic logic signed [ACC_W-1:0] alu(
        input logic [DATA_W-1:0]       op,
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            default: r = a * b;
        endcase
        return r;
    endfunction

    // |MIN| still fits as an unsigned ACC_W value.
    function automatic logic [ACC_W-1:0] magnitude(input logic signed [ACC_W-1:0] x);
        logic [ACC_W-1:0] ux;
        ux = $unsigned(x);
        return x[ACC_W-1] ? (~ux + 1'b1) : ux;
    endfunction

    // Negating 2^(ACC_W-1) gives MIN back, which makes MIN / -1 = MIN.
    function automatic logic signed [ACC_W-1:0] apply_sign(
        input logic [ACC_W-1:0] mag,
        input logic             neg
    );
        return $signed(neg ? (~mag + 1'b1) : mag);
    endfunction

    state_t                  state_q, state_d;
    logic [SP_W-1:0]         sp_q, sp_d;
    logic [2:0]              err_q, err_d;

    logic signed [ACC_W-1:0] stack_q [DEPTH];
    logic                    wr_en;
    logic [IDX_W-1:0]        wr_idx;
    logic signed [ACC_W-1:0] wr_data;

    logic signed [ACC_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]       op_q, op_d;
    logic [ACC_W-1:0]        rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic                    neg_q, neg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    end_mark;
    logic                    op_ok;
    logic [SP_W-1:0]         sp_m1, sp_m2;
    logic [ACC_W:0]          trial, diff;
    logic                    qbit;
    logic [ACC_W-1:0]        rem_nx, quo_nx;

    assign end_mark = bus.number_in_stb && bus.sign_in_stb;
    assign op_ok    = (bus.sign_in == OP_ADD) || (bus.sign_in == OP_SUB) ||
                      (bus.sign_in == OP_MUL) || (bus.sign_in == OP_DIV);
    assign sp_m1    = sp_q - SP_ONE;
    assign sp_m2    = sp_q - SP_TWO;

    // Restoring divide step: shift next dividend bit into the remainder and
    // keep the subtraction only if it did not go negative.
    assign trial  = {rem_q, quo_q[ACC_W-1]};
    assign diff   = trial - {1'b0, dvs_q};
    assign qbit   = ~diff[ACC_W];
    assign rem_nx = qbit ? diff[ACC_W-1:0] : trial[ACC_W-1:0];
    assign quo_nx = {quo_q[ACC_W-2:0], qbit};

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_ACCEPT;
            sp_q    <= '0;
            err_q   <= E_OK;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Stack storage and divide/operand scratch registers carry no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) stack_q[wr_idx] <= wr_data;
        a_q   <= a_d;
        b_q   <= b_d;
        op_q  <= op_d;
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
        neg_q <= neg_d;
        cnt_q <= cnt_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCEPT: begin
                if (end_mark)
                    state_d = S_DONE;
                else if (bus.sign_in_stb && err_q == E_OK && op_ok && sp_q >= SP_TWO)
                    state_d = S_EXEC;
            end
            S_EXEC:   state_d = (op_q == OP_DIV && b_q != '0) ? S_DIV : S_ACCEPT;
            S_DIV:    if (cnt_q == CNT_LAST) state_d = S_ACCEPT;
            S_DONE:   if (bus.result_ack) state_d = S_ACCEPT;
            default:  state_d = S_ACCEPT;
        endcase
    end

    // Stack pointer, error code and datapath updates
    always_comb begin
        sp_d    = sp_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_idx  = sp_q[IDX_W-1:0];
        wr_data = '0;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_ACCEPT: begin
                if (end_mark) begin
                    if (err_q == E_OK && sp_q != SP_ONE) err_d = E_END;
                end else if (bus.number_in_stb) begin
                    if (err_q == E_OK) begin
                        if (sp_q == SP_FULL) begin
                            err_d = E_OVER;
                        end else begin
                            wr_en   = 1'b1;
                            wr_data = $signed({{(ACC_W-DATA_W){1'b0}}, bus.number_in});
                            sp_d    = sp_q + SP_ONE;
                        end
                    end
                end else if (bus.sign_in_stb && err_q == E_OK) begin
                    if (!op_ok) begin
                        err_d = E_SIGN;
                    end else if (sp_q < SP_TWO) begin
                        err_d = E_UNDER;
                    end else begin
                        a_d  = stack_q[sp_m2[IDX_W-1:0]];
                        b_d  = stack_q[sp_m1[IDX_W-1:0]];
                        op_d = bus.sign_in;
                        sp_d = sp_m2;
                    end
                end
            end
            S_EXEC: begin
                if (op_q == OP_DIV) begin
                    if (b_q == '0) begin
                        err_d = E_DIV0;
                    end else begin
                        rem_d = '0;
                        quo_d = magnitude(a_q);
                        dvs_d = magnitude(b_q);
                        neg_d = a_q[ACC_W-1] ^ b_q[ACC_W-1];
                        cnt_d = '0;
                    end
                end else begin
                    wr_en   = 1'b1;
                    wr_data = alu(op_q, a_q, b_q);
                    sp_d    = sp_q + SP_ONE;
                end
            end
            S_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    wr_en   = 1'b1;
                    wr_data = apply_sign(quo_nx, neg_q);
                    sp_d    = sp_q + SP_ONE;
                end
            end
            S_DONE: begin
                if (bus.result_ack) begin
                    sp_d  = '0;
                    err_d = E_OK;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy          = (state_q != S_ACCEPT);
        bus.number_in_ack = (state_q == S_ACCEPT) && bus.number_in_stb;
        bus.sign_in_ack   = (state_q == S_ACCEPT) && bus.sign_in_stb;
        bus.result_stb    = (state_q == S_DONE);
        bus.error         = (state_q == S_DONE) ? err_q : E_OK;
        bus.result        = (state_q == S_DONE && err_q == E_OK) ? $unsigned(stack_q[0]) : '0;
    end
endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed bench for rpn_evaluator: token streams with hand-computed results.
module tb_rpn_evaluator;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rpn_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    rpn_evaluator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a token, wait (bounded) for its ACK, then complete the transfer edge.
    task automatic xfer(input bit do_num, input bit do_sign,
                        input logic [7:0] nv, input logic [7:0] sv, input string tag);
        int  n;
        bit  ok;
        bus.number_in     = nv;
        bus.sign_in       = sv;
        bus.number_in_stb = do_num;
        bus.sign_in_stb   = do_sign;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = (!do_num || bus.number_in_ack) && (!do_sign || bus.sign_in_ack);
            if (!ok) n++;
        end
        check({tag, " ack"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.number_in_stb = 1'b0;
        bus.sign_in_stb   = 1'b0;
    endtask

    task automatic num(input logic [7:0] v, input string tag);
        xfer(1'b1, 1'b0, v, 8'h00, tag);
    endtask

    task automatic op(input logic [7:0] c, input string tag);
        xfer(1'b0, 1'b1, 8'h00, c, tag);
    endtask

    task automatic endm(input string tag);
        xfer(1'b1, 1'b1, 8'h00, 8'h00, tag);
    endtask

    task automatic wait_stb(input string tag);
        int n;
        n = 0;
        while (bus.result_stb !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " stb"}, 32'(bus.result_stb), 32'd1);
    endtask

    task automatic expect_result(input logic [15:0] r, input logic [2:0] e, input string tag);
        wait_stb(tag);
        check({tag, " result"}, 32'(bus.result), 32'(r));
        check({tag, " error"}, 32'(bus.error), 32'(e));
        check({tag, " busy done"}, 32'(bus.busy), 32'd1);
        bus.result_ack = 1'b1;
        @(posedge clk); #1;
        bus.result_ack = 1'b0;
        check({tag, " stb drop"}, 32'(bus.result_stb), 32'd0);
        check({tag, " idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int cyc;
        rst               = 1'b1;
        bus.number_in     = '0;
        bus.sign_in       = '0;
        bus.number_in_stb = 1'b0;
        bus.sign_in_stb   = 1'b0;
        bus.result_ack    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst stb", 32'(bus.result_stb), 32'd0);
        check("rst result", 32'(bus.result), 32'd0);
        check("rst error", 32'(bus.error), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle num ack", 32'(bus.number_in_ack), 32'd0);
        check("idle sign ack", 32'(bus.sign_in_ack), 32'd0);

        // 3 4 + 2 * -> 14, "+" then exactly one busy cycle
        num(8'd3, "e1 n3");
        num(8'd4, "e1 n4");
        op("+", "e1 add");
        check("add exec busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        check("add back idle", 32'(bus.busy), 32'd0);
        num(8'd2, "e1 n2");
        op("*", "e1 mul");
        endm("e1 end");
        expect_result(16'd14, 3'd0, "e1");

        // 2 7 - -> -5
        num(8'd2, "e2 n2");
        num(8'd7, "e2 n7");
        op("-", "e2 sub");
        endm("e2 end");
        expect_result(16'hFFFB, 3'd0, "e2");

        // 200 7 / -> 28, busy for EXEC + 16 divide cycles
        num(8'd200, "e3 n200");
        num(8'd7, "e3 n7");
        op("/", "e3 div");
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("div busy cycles", 32'(cyc), 32'd17);
        endm("e3 end");
        expect_result(16'd28, 3'd0, "e3");

        // 200 0 / 5 + -> div0, later tokens still ACKed
        num(8'd200, "e4 n200");
        num(8'd0, "e4 n0");
        op("/", "e4 div");
        num(8'd5, "e4 n5 after err");
        op("+", "e4 add after err");
        endm("e4 end");
        expect_result(16'd0, 3'd3, "e4");

        // 0 7 - 2 / -> -7/2 = -3 (toward zero)
        num(8'd0, "e5 n0");
        num(8'd7, "e5 n7");
        op("-", "e5 sub");
        num(8'd2, "e5 n2");
        op("/", "e5 div");
        endm("e5 end");
        expect_result(16'hFFFD, 3'd0, "e5");

        // 128 128 * 2 * -> MIN; 0 1 - -> -1; MIN / -1 -> MIN
        num(8'd128, "e6 a");
        num(8'd128, "e6 b");
        op("*", "e6 mul1");
        num(8'd2, "e6 c");
        op("*", "e6 mul2");
        num(8'd0, "e6 d");
        num(8'd1, "e6 e");
        op("-", "e6 sub");
        op("/", "e6 div");
        endm("e6 end");
        expect_result(16'h8000, 3'd0, "e6");

        // 255*255*255 = 16581375 -> wraps to 0x02FF
        num(8'd255, "e7 a");
        num(8'd255, "e7 b");
        op("*", "e7 mul1");
        num(8'd255, "e7 c");
        op("*", "e7 mul2");
        endm("e7 end");
        expect_result(16'h02FF, 3'd0, "e7");

        // underflow
        op("+", "e8 add");
        endm("e8 end");
        expect_result(16'd0, 3'd1, "e8");

        // 17 numbers into a 16-entry stack -> overflow
        for (int i = 1; i <= 17; i++) num(8'(i), "e9 push");
        endm("e9 end");
        expect_result(16'd0, 3'd2, "e9");

        // bad end: two entries left
        num(8'd1, "e10 n1");
        num(8'd2, "e10 n2");
        endm("e10 end");
        expect_result(16'd0, 3'd5, "e10");

        // bad end: empty expression
        endm("e11 end");
        expect_result(16'd0, 3'd5, "e11");

        // bad sign
        num(8'd1, "e12 n1");
        num(8'd2, "e12 n2");
        op("%", "e12 pct");
        endm("e12 end");
        expect_result(16'd0, 3'd4, "e12");

        // result held while RESULT_ACK stays low, no token ACKs meanwhile
        num(8'd3, "e13 n3");
        num(8'd4, "e13 n4");
        op("+", "e13 add");
        endm("e13 end");
        wait_stb("e13");
        bus.number_in     = 8'd9;
        bus.number_in_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold stb", 32'(bus.result_stb), 32'd1);
            check("hold result", 32'(bus.result), 32'd7);
            check("hold no ack", 32'(bus.number_in_ack), 32'd0);
        end
        bus.number_in_stb = 1'b0;
        expect_result(16'd7, 3'd0, "e13");
        num(8'd9, "e14 n9");
        num(8'd1, "e14 n1");
        op("-", "e14 sub");
        endm("e14 end");
        expect_result(16'd8, 3'd0, "e14");

        // reset in the middle of a divide
        num(8'd200, "e15 n200");
        num(8'd7, "e15 n7");
        op("/", "e15 div");
        repeat (5) @(posedge clk);
        #1;
        check("mid div busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst div busy", 32'(bus.busy), 32'd0);
        check("rst div stb", 32'(bus.result_stb), 32'd0);
        check("rst div result", 32'(bus.result), 32'd0);
        check("rst div error", 32'(bus.error), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        num(8'd5, "e16 n5a");
        num(8'd5, "e16 n5b");
        op("*", "e16 mul");
        endm("e16 end");
        expect_result(16'd25, 3'd0, "e16");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
